// File: rtl/yasu_drawer_if.sv
// Signal bundle between the frame-update engine, the game logic, the
// character sprite lookup and the VGA adapter.
interface yasu_drawer_if;
    logic       start;
    logic [7:0] new_x;
    logic [6:0] new_y;
    logic [7:0] pix_x;
    logic [6:0] pix_y;
    logic [7:0] spr_x;
    logic [6:0] spr_y;
    logic [2:0] spr_color;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot;
    logic       busy;
    logic       done;

    modport slave (
        input  start, new_x, new_y, spr_color,
        output pix_x, pix_y, spr_x, spr_y, vga_x, vga_y, vga_colour, plot, busy, done
    );

    modport master (
        output start, new_x, new_y, spr_color,
        input  pix_x, pix_y, spr_x, spr_y, vga_x, vga_y, vga_colour, plot, busy, done
    );
endinterface

// File: rtl/yasu_drawer.sv
// Frame-update engine: erases the sprite box at the previous anchor with the
// background colour, then rasterises it at the new anchor, one VGA write per cycle.
module yasu_drawer #(
    parameter int         BOX_W    = 16,
    parameter int         BOX_H    = 32,
    parameter logic [2:0] BG_COLOR = 3'b111,
    parameter int         SCREEN_W = 160
) (
    input  logic          clk,
    input  logic          resetn,
    yasu_drawer_if.slave  bus
);

    localparam logic [3:0] CX_LAST = 4'(BOX_W - 1);
    localparam logic [4:0] CY_LAST = 5'(BOX_H - 1);
    localparam logic [8:0] X_LIMIT = 9'(SCREEN_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ERASE = 2'd1,
        ST_DRAW  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cur_x_q, cur_x_d, old_x_q, old_x_d;
    logic [6:0] cur_y_q, cur_y_d, old_y_q, old_y_d;
    logic       have_old_q, have_old_d;
    logic [3:0] cx_q, cx_d;
    logic [4:0] cy_q, cy_d;

    logic [7:0] vga_x_q;
    logic [6:0] vga_y_q;
    logic [2:0] vga_colour_q;
    logic       plot_q, busy_q, done_q;

    logic       erase_s, active_s, last_pix_s, clip_s, plot_d;
    logic [7:0] anchor_x_s, pix_x_s;
    logic [6:0] anchor_y_s, pix_y_s;
    logic [8:0] x_sum_s;
    logic [2:0] colour_d;

    // Pixel address, clipping and colour for the current counter slot.
    always_comb begin
        erase_s    = (state_q == ST_ERASE);
        active_s   = erase_s || (state_q == ST_DRAW);
        last_pix_s = (cx_q == CX_LAST) && (cy_q == CY_LAST);
        anchor_x_s = erase_s ? old_x_q : cur_x_q;
        anchor_y_s = erase_s ? old_y_q : cur_y_q;
        // Nine-bit sum so a box straddling x=255 cannot wrap back on screen.
        x_sum_s    = {1'b0, anchor_x_s} + {5'd0, cx_q};
        pix_x_s    = x_sum_s[7:0];
        pix_y_s    = anchor_y_s - {2'd0, cy_q};
        clip_s     = (x_sum_s >= X_LIMIT) || ({2'd0, cy_q} > anchor_y_s);
        plot_d     = active_s && !clip_s;
        colour_d   = erase_s ? BG_COLOR : bus.spr_color;
    end

    // Sequencer next state: anchor latching, box scan and phase changes.
    always_comb begin
        state_d    = state_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        old_x_d    = old_x_q;
        old_y_d    = old_y_q;
        have_old_d = have_old_q;
        cx_d       = cx_q;
        cy_d       = cy_q;

        if (active_s) begin
            if (cx_q == CX_LAST) begin
                cx_d = 4'd0;
                cy_d = cy_q + 5'd1;
            end else begin
                cx_d = cx_q + 4'd1;
            end
        end else begin
            cx_d = cx_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    old_x_d = cur_x_q;
                    old_y_d = cur_y_q;
                    cur_x_d = bus.new_x;
                    cur_y_d = bus.new_y;
                    cx_d    = 4'd0;
                    cy_d    = 5'd0;
                    state_d = have_old_q ? ST_ERASE : ST_DRAW;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERASE: begin
                if (last_pix_s) begin
                    cx_d    = 4'd0;
                    cy_d    = 5'd0;
                    state_d = ST_DRAW;
                end else begin
                    state_d = ST_ERASE;
                end
            end
            ST_DRAW: begin
                if (last_pix_s) begin
                    cx_d       = 4'd0;
                    cy_d       = 5'd0;
                    have_old_d = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    state_d = ST_DRAW;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and anchor registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            cur_x_q    <= 8'd0;
            cur_y_q    <= 7'd0;
            old_x_q    <= 8'd0;
            old_y_q    <= 7'd0;
            have_old_q <= 1'b0;
            cx_q       <= 4'd0;
            cy_q       <= 5'd0;
        end else begin
            state_q    <= state_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            old_x_q    <= old_x_d;
            old_y_q    <= old_y_d;
            have_old_q <= have_old_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
        end
    end

    // Write pipeline stage and status flags; flags follow the next state so
    // they line up with the state they describe.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vga_x_q      <= 8'd0;
            vga_y_q      <= 7'd0;
            vga_colour_q <= 3'd0;
            plot_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            vga_x_q      <= pix_x_s;
            vga_y_q      <= pix_y_s;
            vga_colour_q <= colour_d;
            plot_q       <= plot_d;
            busy_q       <= (state_d != ST_IDLE);
            done_q       <= (state_d == ST_DONE);
        end
    end

    assign bus.pix_x      = pix_x_s;
    assign bus.pix_y      = pix_y_s;
    assign bus.spr_x      = cur_x_q;
    assign bus.spr_y      = cur_y_q;
    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = vga_colour_q;
    assign bus.plot       = plot_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_yasu_drawer.sv
// Scoreboard bench for yasu_drawer: expected VGA writes are queued when an
// update is started and compared as plot cycles appear.
module tb_yasu_drawer;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } wr_t;

    logic clk;
    logic resetn;
    int   checks;
    int   errors;
    int   plot_cnt;
    wr_t  exp_q[$];

    logic       m_have_old;
    logic [7:0] m_cur_x;
    logic [6:0] m_cur_y;

    yasu_drawer_if bus();

    yasu_drawer dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] spr_fn(input logic [3:0] dx, input logic [4:0] dy);
        return {dx[3] ^ dy[4], dx[1] ^ dy[0], dx[0] ^ dy[2]};
    endfunction

    // Sprite lookup stand-in: colour depends only on the offset inside the box.
    always_comb begin
        logic [7:0] dx;
        logic [6:0] dy;
        dx = bus.pix_x - bus.spr_x;
        dy = bus.spr_y - bus.pix_y;
        bus.spr_color = spr_fn(dx[3:0], dy[4:0]);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_box(input logic [7:0] ax, input logic [6:0] ay, input logic erase);
        wr_t w;
        for (int cy = 0; cy < 32; cy++) begin
            for (int cx = 0; cx < 16; cx++) begin
                if ((int'(ax) + cx) < 160 && cy <= int'(ay)) begin
                    w.x = 8'(int'(ax) + cx);
                    w.y = 7'(int'(ay) - cy);
                    w.c = erase ? 3'b111 : spr_fn(4'(cx), 5'(cy));
                    exp_q.push_back(w);
                end
            end
        end
    endtask

    // Write monitor: every plot cycle consumes one scoreboard entry.
    always @(negedge clk) begin
        if (resetn && bus.plot) begin
            wr_t e;
            plot_cnt++;
            check_val("x_on_screen", 32'(bus.vga_x < 8'd160), 32'd1);
            if (exp_q.size() == 0) begin
                check_val("extra_plot", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("vga_x", 32'(bus.vga_x), 32'(e.x));
                check_val("vga_y", 32'(bus.vga_y), 32'(e.y));
                check_val("vga_colour", 32'(bus.vga_colour), 32'(e.c));
            end
        end
    end

    task automatic run_update(input logic [7:0] nx, input logic [6:0] ny,
                              input int exp_done, input int exp_plots,
                              input int pulse_at, input int reset_at);
        int n, done_n, done_cnt, plots0;
        if (m_have_old) push_box(m_cur_x, m_cur_y, 1'b1);
        push_box(nx, ny, 1'b0);
        m_cur_x = nx;
        m_cur_y = ny;
        m_have_old = 1'b1;
        plots0 = plot_cnt;
        done_n = 0;
        done_cnt = 0;

        @(negedge clk);
        bus.new_x = nx;
        bus.new_y = ny;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (n = 1; n < 1200; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check_val("busy_start", 32'(bus.busy), 32'd1);
                check_val("spr_x", 32'(bus.spr_x), 32'(nx));
                check_val("spr_y", 32'(bus.spr_y), 32'(ny));
            end
            if (n == pulse_at) begin
                bus.new_x = 8'd99;
                bus.new_y = 7'd99;
                bus.start = 1'b1;
            end
            if (n == pulse_at + 1) bus.start = 1'b0;
            if (n == reset_at) begin
                resetn = 1'b0;
                #1;
                check_val("rst_plot", 32'(bus.plot), 32'd0);
                check_val("rst_busy", 32'(bus.busy), 32'd0);
                check_val("rst_done", 32'(bus.done), 32'd0);
                exp_q.delete();
                m_have_old = 1'b0;
                m_cur_x = 8'd0;
                m_cur_y = 7'd0;
                repeat (3) @(negedge clk);
                resetn = 1'b1;
                return;
            end
            if (bus.done) begin
                done_cnt++;
                if (done_n == 0) done_n = n;
            end
            if (done_n != 0 && n == done_n + 1) check_val("busy_idle", 32'(bus.busy), 32'd0);
            if (done_n != 0 && n == done_n + 3) break;
        end
        if (done_n == 0) check_val("done_timeout", 32'd0, 32'd1);
        check_val("done_cycle", 32'(done_n), 32'(exp_done));
        check_val("done_count", 32'(done_cnt), 32'd1);
        check_val("plot_count", 32'(plot_cnt - plots0), 32'(exp_plots));
        check_val("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        plot_cnt = 0;
        m_have_old = 1'b0;
        m_cur_x = 8'd0;
        m_cur_y = 7'd0;
        resetn = 1'b0;
        bus.start = 1'b0;
        bus.new_x = 8'd0;
        bus.new_y = 7'd0;
        repeat (3) @(negedge clk);
        check_val("reset_plot", 32'(bus.plot), 32'd0);
        check_val("reset_busy", 32'(bus.busy), 32'd0);
        check_val("reset_done", 32'(bus.done), 32'd0);
        check_val("reset_vga_x", 32'(bus.vga_x), 32'd0);
        check_val("reset_spr_x", 32'(bus.spr_x), 32'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        run_update(8'd20, 7'd60, 513, 512, -10, -10);    // first draw
        run_update(8'd40, 7'd80, 1025, 1024, -10, -10);  // move
        run_update(8'd60, 7'd100, 1025, 1024, 700, -10); // start ignored during DRAW
        run_update(8'd150, 7'd60, 1025, 832, -10, -10);  // right-edge clip: 512 + 320
        run_update(8'd30, 7'd10, 1025, 496, -10, -10);   // top clip: 320 + 176
        run_update(8'd5, 7'd40, 1025, 1024, -10, 300);   // reset mid-erase
        run_update(8'd20, 7'd60, 513, 512, -10, -10);    // post-reset skips erase

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
